// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one external asynchronous 1M x 16 SRAM between two requesters that
// run on the 200 MHz clock. Port A (chip-RAM / DRAM emulation) has fixed
// priority over port B (host / Pi side). Each port uses a toggle handshake:
// a request is pending while req != ack, and the arbiter flips ack to match
// req once the access is complete.
//
// Every access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> FINISH ->
// IDLE. All SRAM pins are driven from registers, so the pins change only on
// clock edges.
//
// Optional build macro:
//   SRAM_ARB_STARVE_GUARD_EN - after STARVE_LIMIT consecutive A grants made
//   while B is waiting, the next grant goes to B. Without the macro, A has
//   strict priority and B can starve.
//
// Parameters:
//   ACCESS_CYCLES  clk200 cycles OE_n/WE_n are held low (1..7)
//   STARVE_LIMIT   A grants tolerated while B waits (guard build only, 1..7)
//
// Ports:
//   clk200, reset            clock and synchronous active-high reset
//   a_req / a_ack            port A request / acknowledge toggles
//   a_read                   1 = read, 0 = write
//   a_address, a_lb, a_ub    word address and active-high byte enables
//   a_wdata / a_rdata        write data in / read data out
//   b_*                      the same set of signals for port B
//   SRAM_A, SRAM_D           SRAM address and bidirectional data bus
//   SRAM_CE_n, SRAM_OE_n,
//   SRAM_WE_n, SRAM_LB_n,
//   SRAM_UB_n                active-low SRAM control strobes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk200,
  input  logic        reset,

  input  logic        a_req,
  output logic        a_ack,
  input  logic        a_read,
  input  logic [19:0] a_address,
  input  logic        a_lb,
  input  logic        a_ub,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,

  input  logic        b_req,
  output logic        b_ack,
  input  logic        b_read,
  input  logic [19:0] b_address,
  input  logic        b_lb,
  input  logic        b_ub,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,

  output logic [19:0] SRAM_A,
  inout  wire  [15:0] SRAM_D,
  output logic        SRAM_CE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_WE_n,
  output logic        SRAM_LB_n,
  output logic        SRAM_UB_n
);

  // Elaboration-time parameter range checks. The counters are 3 bits wide.
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 7) begin : gBadAccessCycles
    $error("sram_arbiter: ACCESS_CYCLES must be in 1..7");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : gBadStarveLimit
    $error("sram_arbiter: STARVE_LIMIT must be in 1..7");
  end

  localparam logic [2:0] ACCESS_LOAD = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    FINISH = 2'd3
  } StateT;

  StateT       state_q, state_d;
  logic [2:0]  accessCnt_q, accessCnt_d;

  // Transaction latched at grant time. The owner's inputs may change freely
  // after the grant.
  logic        owner_q, owner_d;        // 0 = port A, 1 = port B
  logic        isRead_q, isRead_d;
  logic [19:0] addr_q, addr_d;
  logic        lbEn_q, lbEn_d;
  logic        ubEn_q, ubEn_d;
  logic [15:0] wdata_q, wdata_d;

  logic        aAck_q, aAck_d;
  logic        bAck_q, bAck_d;
  logic [15:0] aRdata_q, aRdata_d;
  logic [15:0] bRdata_q, bRdata_d;

  // Registered SRAM pin drivers.
  logic [19:0] sramA_q, sramA_d;
  logic        ceN_q, ceN_d;
  logic        oeN_q, oeN_d;
  logic        weN_q, weN_d;
  logic        lbN_q, lbN_d;
  logic        ubN_q, ubN_d;
  logic        driveEn_q, driveEn_d;

  logic        pa, pb;
  logic        grantA, grantB;
  logic        captureEdge;

  assign pa = a_req ^ aAck_q;
  assign pb = b_req ^ bAck_q;

  // The edge that ends the final ACCESS cycle. Read data is sampled here
  // while OE_n is still low.
  assign captureEdge = (state_q == ACCESS) && (accessCnt_q == 3'd0);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [2:0] starveCnt_q, starveCnt_d;
  logic       forceB;

  assign forceB = pb && (starveCnt_q == STARVE_MAX);
`endif

  // Arbitration happens only in IDLE. A wins a tie unless the starvation
  // guard is built in and B has already waited through STARVE_LIMIT A grants.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (state_q == IDLE) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
      if (forceB) begin
        grantB = 1'b1;
      end else if (pa) begin
        grantA = 1'b1;
      end else if (pb) begin
        grantB = 1'b1;
      end
`else
      if (pa) begin
        grantA = 1'b1;
      end else if (pb) begin
        grantB = 1'b1;
      end
`endif
    end
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  // The counter tracks A grants made while B is waiting. It clears as soon
  // as B is no longer waiting or is granted, and it saturates at the limit.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!pb || grantB) begin
      starveCnt_d = 3'd0;
    end else if (grantA && (starveCnt_q != STARVE_MAX)) begin
      starveCnt_d = starveCnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk200) begin
    if (reset) begin
      starveCnt_q <= 3'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`endif

  // Next-state logic for the access sequencer, transaction latch, acks and
  // read-data capture.
  always_comb begin
    state_d     = state_q;
    accessCnt_d = accessCnt_q;
    owner_d     = owner_q;
    isRead_d    = isRead_q;
    addr_d      = addr_q;
    lbEn_d      = lbEn_q;
    ubEn_d      = ubEn_q;
    wdata_d     = wdata_q;
    aAck_d      = aAck_q;
    bAck_d      = bAck_q;
    aRdata_d    = aRdata_q;
    bRdata_d    = bRdata_q;

    case (state_q)
      IDLE: begin
        if (grantA) begin
          owner_d  = 1'b0;
          isRead_d = a_read;
          addr_d   = a_address;
          lbEn_d   = a_lb;
          ubEn_d   = a_ub;
          wdata_d  = a_wdata;
          state_d  = SETUP;
        end else if (grantB) begin
          owner_d  = 1'b1;
          isRead_d = b_read;
          addr_d   = b_address;
          lbEn_d   = b_lb;
          ubEn_d   = b_ub;
          wdata_d  = b_wdata;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        accessCnt_d = ACCESS_LOAD;
        state_d     = ACCESS;
      end

      ACCESS: begin
        if (accessCnt_q == 3'd0) begin
          state_d = FINISH;
        end else begin
          accessCnt_d = accessCnt_q - 3'd1;
        end
      end

      FINISH: begin
        // Toggling ack on this edge is what lets the requester issue its next
        // request. IDLE then sees the new request on its first cycle.
        if (owner_q) begin
          bAck_d = ~bAck_q;
        end else begin
          aAck_d = ~aAck_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (captureEdge && isRead_q) begin
      if (owner_q) begin
        bRdata_d = SRAM_D;
      end else begin
        aRdata_d = SRAM_D;
      end
    end
  end

  // SRAM pin values are decoded from the next state, so the registered pins
  // line up exactly with the state they belong to. The data bus drive enable
  // is only ever set for writes, and OE_n is only ever low for reads, so the
  // two sides never fight over SRAM_D.
  always_comb begin
    sramA_d   = sramA_q;
    ceN_d     = 1'b1;
    oeN_d     = 1'b1;
    weN_d     = 1'b1;
    lbN_d     = 1'b1;
    ubN_d     = 1'b1;
    driveEn_d = 1'b0;

    if (state_d != IDLE) begin
      sramA_d   = addr_d;
      ceN_d     = 1'b0;
      lbN_d     = ~lbEn_d;
      ubN_d     = ~ubEn_d;
      driveEn_d = ~isRead_d;
    end

    if (state_d == ACCESS) begin
      oeN_d = ~isRead_d;
      weN_d = isRead_d;
    end
  end

  // State registers. Reset aborts any access in flight: the ack is not
  // toggled and every strobe returns to inactive on the same edge.
  always_ff @(posedge clk200) begin
    if (reset) begin
      state_q     <= IDLE;
      accessCnt_q <= 3'd0;
      owner_q     <= 1'b0;
      isRead_q    <= 1'b1;
      addr_q      <= 20'd0;
      lbEn_q      <= 1'b0;
      ubEn_q      <= 1'b0;
      wdata_q     <= 16'd0;
      aAck_q      <= 1'b0;
      bAck_q      <= 1'b0;
      aRdata_q    <= 16'd0;
      bRdata_q    <= 16'd0;
      sramA_q     <= 20'd0;
      ceN_q       <= 1'b1;
      oeN_q       <= 1'b1;
      weN_q       <= 1'b1;
      lbN_q       <= 1'b1;
      ubN_q       <= 1'b1;
      driveEn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      accessCnt_q <= accessCnt_d;
      owner_q     <= owner_d;
      isRead_q    <= isRead_d;
      addr_q      <= addr_d;
      lbEn_q      <= lbEn_d;
      ubEn_q      <= ubEn_d;
      wdata_q     <= wdata_d;
      aAck_q      <= aAck_d;
      bAck_q      <= bAck_d;
      aRdata_q    <= aRdata_d;
      bRdata_q    <= bRdata_d;
      sramA_q     <= sramA_d;
      ceN_q       <= ceN_d;
      oeN_q       <= oeN_d;
      weN_q       <= weN_d;
      lbN_q       <= lbN_d;
      ubN_q       <= ubN_d;
      driveEn_q   <= driveEn_d;
    end
  end

  assign a_ack     = aAck_q;
  assign b_ack     = bAck_q;
  assign a_rdata   = aRdata_q;
  assign b_rdata   = bRdata_q;

  assign SRAM_A    = sramA_q;
  assign SRAM_CE_n = ceN_q;
  assign SRAM_OE_n = oeN_q;
  assign SRAM_WE_n = weN_q;
  assign SRAM_LB_n = lbN_q;
  assign SRAM_UB_n = ubN_q;
  assign SRAM_D    = driveEn_q ? wdata_q : 16'hzzzz;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external asynchronous 16-bit SRAM (1M x 16) between two clk200-domain requesters.
- Port A is the chip-RAM DRAM emulation port and has fixed high priority. Port B is the host/Pi side.
- Both ports use the toggle handshake: a request is pending while req != ack. The arbiter toggles ack to equal req when the access completes.
- Generates the SRAM pin timing and returns read data per port.

Parameters:
- ACCESS_CYCLES, 2: number of clk200 cycles OE_n/WE_n are held asserted (2 = 10 ns). Legal range 1..7.
- STARVE_LIMIT, 4: consecutive A grants allowed while B is pending. Used only with the optional feature.

Ports:
- clk200 input 1: 200 MHz clock; all logic on its rising edge.
- reset input 1: synchronous, active-high reset.
- a_req input 1: port A request toggle.
- a_ack output 1: port A acknowledge toggle.
- a_read input 1: 1 = read, 0 = write.
- a_address input 20: word address.
- a_lb input 1: lower byte enable, active high.
- a_ub input 1: upper byte enable, active high.
- a_wdata input 16: write data.
- a_rdata output 16: read data.
- b_req, b_ack, b_read, b_address, b_lb, b_ub, b_wdata, b_rdata: same as port A, for port B.
- SRAM_A output 20: SRAM address.
- SRAM_D inout 16: SRAM data bus.
- SRAM_CE_n output 1: chip enable, active low.
- SRAM_OE_n output 1: output enable, active low.
- SRAM_WE_n output 1: write enable, active low.
- SRAM_LB_n output 1: lower byte select, active low.
- SRAM_UB_n output 1: upper byte select, active low.

Behaviour:
- Reset values:
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - SRAM_CE_n = SRAM_OE_n = SRAM_WE_n = SRAM_LB_n = SRAM_UB_n = 1; SRAM_A = 0.
  - SRAM_D released (Z); state = IDLE; starve counter = 0.
- Reset mid-access aborts the access immediately. The ack is not toggled and all controls return to inactive on the next edge.
- After reset, any req that differs from its ack is treated as pending and is serviced.
- Pending: pa = a_req ^ a_ack, pb = b_req ^ b_ack.
- IDLE:
  - If pa, grant A; else if pb, grant B; else stay in IDLE.
  - On grant, latch into internal registers: owner, read, address, lb, ub, wdata. Requester inputs may change after grant without effect.
  - Go to SETUP.
- SETUP (1 cycle):
  - SRAM_A = latched address; CE_n = 0.
  - LB_n = !lb, UB_n = !ub.
  - OE_n = 1, WE_n = 1.
  - On a write, drive SRAM_D = wdata from this cycle onward.
- ACCESS (ACCESS_CYCLES cycles, down-counter):
  - On a read, OE_n = 0; on a write, WE_n = 0.
  - On a read, sample SRAM_D into the owner's rdata on the edge that ends the last ACCESS cycle.
- FINISH (1 cycle):
  - OE_n = WE_n = 1. CE_n, address and byte selects are held.
  - On a write, data stays driven (hold time).
  - The owner's ack is toggled on the edge leaving FINISH. Next state is IDLE, and CE_n = 1 in IDLE.
- Latency: a request pending in IDLE at edge 0 gets its ack toggled at edge ACCESS_CYCLES + 3. That is 5 cycles at the default, and the access occupies the SRAM for 4 cycles of that.
- Back-to-back: IDLE re-arbitrates on its first cycle, so the minimum spacing between accesses is ACCESS_CYCLES + 3 cycles.
- Simultaneous pa and pb: A wins; B waits and is granted in the next IDLE if A is not pending.
- A new toggle on an already-owned port while its access is in flight is not possible under the protocol (req only toggles after ack). It is ignored until FINISH, and is then seen as pending.
- Byte enables both 0: the full cycle runs with LB_n = UB_n = 1, so there is no SRAM effect. For a read, rdata captures the bus value; the ack is still toggled.
- Bus turnaround: SRAM_D is never driven while OE_n = 0. Drive enable is registered and asserted only in SETUP, ACCESS and FINISH of writes.
- rdata of a port changes only at the capture edge of that port's own reads and is held otherwise.

Optional Feature:
- Macro: SRAM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter increments on each A grant made while pb is set, and clears on any B grant or when pb = 0.
  - When the counter equals STARVE_LIMIT and pb is set, B is granted even if pa is set. The counter then clears.
  - Count width is 3 bits; saturate at STARVE_LIMIT.
- Without the macro: strict A priority, no counter logic; B can starve indefinitely.

Test Plan:
- A read:
  - Stimulus: preload SRAM model word 0x12345 = 0xBEEF; toggle a_req with a_read=1, lb=ub=1.
  - Required response: SRAM_A = 0x12345 with OE_n low for exactly 2 cycles; a_rdata = 0xBEEF and a_ack toggles 5 cycles after the request.
- B write with only the upper byte:
  - Stimulus: b_address = 0x00010, b_wdata = 0xA55A, b_ub=1, b_lb=0.
  - Required response: WE_n low for 2 cycles, UB_n=0, LB_n=1, SRAM_D driven from SETUP through FINISH; the model holds 0xA5 in the upper byte with the lower byte unchanged; b_ack toggles.
- Collision:
  - Stimulus: toggle a_req and b_req on the same cycle.
  - Required response: A serviced first; B granted in the IDLE following A's FINISH; b_ack toggles 10 cycles after the requests; OE_n and WE_n are never low together.
- Starvation:
  - Stimulus: B pending while A re-requests immediately after every ack.
  - Required response: without the macro, B is never granted over 20 A accesses; with SRAM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, B is granted after exactly 4 A grants.
- Reset mid-write:
  - Stimulus: assert reset during ACCESS of an A write.
  - Required response: the next edge gives WE_n=1, CE_n=1, SRAM_D=Z, a_ack=0; with a_req=1 held, the access is re-serviced after reset deasserts.
- Byte enables zero:
  - Stimulus: A write with lb=ub=0.
  - Required response: LB_n=UB_n=1 throughout, SRAM contents unchanged, a_ack still toggles at 5 cycles.
